// File: rtl/signal_acq_core_pkg.sv
// Shared types and fixed field widths for the NMR echo acquisition front end.
package signal_acq_core_pkg;

  localparam int PER_W = 4;
  localparam int ADD_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STRIP,
    ST_ACQ,
    ST_DONE
  } acq_state_e;

endpackage

// File: rtl/acq_clk_div.sv
// ADC conversion clock divider: half-period of half_m1_i+1 cycles, low while disabled.
// strobe_o marks the cycle in which the clock is driven from low to high.
module acq_clk_div
  import signal_acq_core_pkg::*;
(
  input  logic             clk_sys,
  input  logic             s_reset,
  input  logic             en_i,
  input  logic [PER_W-1:0] half_m1_i,
  output logic             acq_clk_o,
  output logic             strobe_o
);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;

  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    strobe_o = 1'b0;
    if (!en_i) begin
      // Preloading while idle puts the first rising edge H cycles after enable.
      cnt_d = half_m1_i;
      clk_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d    = half_m1_i;
      clk_d    = ~clk_q;
      strobe_o = ~clk_q;
    end else begin
      cnt_d = cnt_q - PER_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (s_reset) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  // Gating with enable forces the pin low in the very first cycle outside a run.
  assign acq_clk_o = clk_q & en_i;

endmodule

// File: rtl/signal_acq_core.sv
// Echo acquisition core: strips leading ADC samples, then sums captured samples
// in groups of 1..32 and emits each group sum with a one-cycle valid strobe.
module signal_acq_core
  import signal_acq_core_pkg::*;
#(
  parameter int ADC_W   = 12,
  parameter int NUM_W   = 16,
  parameter int STRIP_W = 12,
  parameter int DATA_W  = 17
) (
  input  logic               clk_sys,
  input  logic               s_reset,
  input  logic               signal_load,
  input  logic               s_acq_en,
  input  logic [NUM_W-1:0]   acqnum,
  input  logic [STRIP_W-1:0] stripnum,
  input  logic [PER_W-1:0]   s_periodnum,
  input  logic [ADD_W-1:0]   s_addchoice,
  input  logic [ADC_W-1:0]   s_ADC,
  output logic               Signal_acq_clk,
  output logic [DATA_W-1:0]  signal_data,
  output logic               signal_valid,
  output logic               acq_done
);

  if (DATA_W < ADC_W + 5) begin : g_width_check
    $error("signal_acq_core: DATA_W must hold 32 full-scale samples");
  end

  acq_state_e         state_q, state_d;
  logic [NUM_W-1:0]   acq_l_q, acq_l_d;
  logic [STRIP_W-1:0] strip_l_q, strip_l_d;
  logic [PER_W-1:0]   per_l_q, per_l_d;
  logic [ADD_W-1:0]   add_l_q, add_l_d;
  logic [NUM_W-1:0]   cnt_q, cnt_d;
  logic [ADD_W-1:0]   grp_q, grp_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               en_q;

  logic               load_now;
  logic               rise;
  logic               running;
  logic               abort;
  logic               strobe;
  logic [DATA_W-1:0]  sum;

  // A load in the same IDLE cycle as the start edge must already govern that run.
  assign load_now  = (state_q == ST_IDLE) && signal_load;
  assign acq_l_d   = load_now ? acqnum      : acq_l_q;
  assign strip_l_d = load_now ? stripnum    : strip_l_q;
  assign per_l_d   = load_now ? s_periodnum : per_l_q;
  assign add_l_d   = load_now ? s_addchoice : add_l_q;

  assign rise    = s_acq_en & ~en_q;
  assign running = (state_q == ST_STRIP) || (state_q == ST_ACQ);
  assign abort   = running & ~s_acq_en;
  assign sum     = acc_q + DATA_W'(s_ADC);

  acq_clk_div u_clk_div (
    .clk_sys   (clk_sys),
    .s_reset   (s_reset),
    .en_i      (running),
    .half_m1_i (per_l_d),
    .acq_clk_o (Signal_acq_clk),
    .strobe_o  (strobe)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        grp_d = add_l_d;
        acc_d = '0;
        if (rise) begin
          if (strip_l_d != '0) begin
            state_d = ST_STRIP;
            cnt_d   = NUM_W'(strip_l_d);
          end else begin
            state_d = ST_ACQ;
            cnt_d   = acq_l_d;
          end
        end
      end
      ST_STRIP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = (acq_l_q == '0) ? ST_DONE : ST_ACQ;
          cnt_d   = acq_l_q;
        end else if (strobe) begin
          cnt_d = cnt_q - NUM_W'(1);
        end
      end
      ST_ACQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (strobe) begin
          cnt_d = cnt_q - NUM_W'(1);
          // Close the group on its G-th sample, or early on the final sample.
          if ((grp_q == '0) || (cnt_q == NUM_W'(1))) begin
            data_d  = sum;
            valid_d = 1'b1;
            acc_d   = '0;
            grp_d   = add_l_q;
          end else begin
            acc_d = sum;
            grp_d = grp_q - ADD_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (s_reset) begin
      state_q   <= ST_IDLE;
      acq_l_q   <= '0;
      strip_l_q <= '0;
      per_l_q   <= '0;
      add_l_q   <= '0;
      cnt_q     <= '0;
      grp_q     <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acq_l_q   <= acq_l_d;
      strip_l_q <= strip_l_d;
      per_l_q   <= per_l_d;
      add_l_q   <= add_l_d;
      cnt_q     <= cnt_d;
      grp_q     <= grp_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      en_q      <= s_acq_en;
    end
  end

  assign signal_data  = data_q;
  assign signal_valid = valid_q;
  assign acq_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_signal_acq_core.sv
// Bench for signal_acq_core: table of runs plus random runs against a timing/arithmetic model.
module tb_signal_acq_core;

  logic        clk_sys = 1'b0;
  logic        s_reset;
  logic        signal_load;
  logic        s_acq_en;
  logic [15:0] acqnum;
  logic [11:0] stripnum;
  logic [3:0]  s_periodnum;
  logic [4:0]  s_addchoice;
  logic [11:0] s_ADC;
  logic        Signal_acq_clk;
  logic [16:0] signal_data;
  logic        signal_valid;
  logic        acq_done;

  int checks   = 0;
  int failures = 0;
  int exp_data = 0;
  int samp[256];

  typedef struct {
    int per;
    int strip;
    int acq;
    int add;
    int pat;        // 0 constant, 1 ramp 1,2,3.., 2 random
    int cval;
    int abort_n;    // drop s_acq_en after this many strobes (0 = never)
    int mid_load;
    int same_cyc;
    int exp_nvalid;
    int exp_first;  // -1 = not checked
    int exp_ndone;
  } vec_t;

  always #5 clk_sys = ~clk_sys;

  signal_acq_core dut (
    .clk_sys        (clk_sys),
    .s_reset        (s_reset),
    .signal_load    (signal_load),
    .s_acq_en       (s_acq_en),
    .acqnum         (acqnum),
    .stripnum       (stripnum),
    .s_periodnum    (s_periodnum),
    .s_addchoice    (s_addchoice),
    .s_ADC          (s_ADC),
    .Signal_acq_clk (Signal_acq_clk),
    .signal_data    (signal_data),
    .signal_valid   (signal_valid),
    .acq_done       (acq_done)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Index of the sample strobe falling in run cycle k, or -1.
  function automatic int strobe_idx(input int k, input int h, input int s);
    int d;
    if (k < h - 1) return -1;
    d = k - (h - 1);
    if ((d % (2 * h)) != 0) return -1;
    if ((d / (2 * h)) >= s) return -1;
    return d / (2 * h);
  endfunction

  task automatic run_vec(input vec_t v, output int nvalid, output int first, output int ndone);
    int  h, g, s, kl, done_k, ka, kend, idx, a, sum;
    bit  live, vexp;
    h = v.per + 1;
    g = v.add + 1;
    s = v.strip + v.acq;
    kl = h - 1 + 2 * h * (s - 1);
    done_k = (s == 0) ? 1 : kl + 2;
    ka = (v.abort_n > 0) ? h - 1 + 2 * h * (v.abort_n - 1) + 1 : 32'h3fff_ffff;
    kend = (v.abort_n > 0) ? ka + 4 : done_k + 4;
    for (int i = 0; i < v.acq; i++)
      samp[i] = (v.pat == 0) ? v.cval : (v.pat == 1) ? i + 1 : int'($urandom_range(0, 4095));
    nvalid = 0;
    first  = -1;
    ndone  = 0;
    @(negedge clk_sys);
    acqnum      = 16'(v.acq);
    stripnum    = 12'(v.strip);
    s_periodnum = 4'(v.per);
    s_addchoice = 5'(v.add);
    signal_load = 1'b1;
    if (!v.same_cyc) begin
      @(negedge clk_sys);
      signal_load = 1'b0;
    end
    s_acq_en = 1'b1;
    for (int k = 0; k <= kend; k++) begin
      @(negedge clk_sys);
      live = (v.abort_n == 0) || (k <= ka);
      vexp = 1'b0;
      idx  = strobe_idx(k - 1, h, s);
      if (live && idx >= v.strip) begin
        a = idx - v.strip;
        if (((a + 1) % g == 0) || (a == v.acq - 1)) begin
          vexp = 1'b1;
          sum  = 0;
          for (int j = a - (a % g); j <= a; j++) sum += samp[j];
          exp_data = sum;
        end
      end
      chk("acq_clk", int'(Signal_acq_clk), int'(live && k < done_k && ((k / h) % 2 == 1)));
      chk("valid", int'(signal_valid), int'(vexp));
      chk("done", int'(acq_done), int'(v.abort_n == 0 && k == done_k));
      chk("data", int'(signal_data), exp_data);
      if (signal_valid) begin
        nvalid++;
        if (first < 0) first = int'(signal_data);
      end
      if (acq_done) ndone++;
      signal_load = 1'b0;
      idx = strobe_idx(k, h, s);
      if (idx >= v.strip) s_ADC = 12'(samp[idx - v.strip]);
      else s_ADC = 12'($urandom_range(0, 4095));
      if (k == ka) s_acq_en = 1'b0;
      if (v.mid_load != 0 && k == 3) begin
        acqnum      = 16'd3;
        stripnum    = 12'd0;
        s_periodnum = 4'd0;
        s_addchoice = 5'd0;
        signal_load = 1'b1;
      end
    end
    s_acq_en = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   nv, fd, nd;

  initial begin
    tbl[0] = '{0, 2, 4, 1, 0, 100, 0, 0, 0, 2, 200, 1};
    tbl[1] = '{3, 0, 5, 2, 1, 0, 0, 0, 0, 2, 6, 1};
    tbl[2] = '{0, 0, 32, 31, 0, 4095, 0, 0, 0, 1, 131040, 1};
    tbl[3] = '{0, 0, 100, 3, 2, 0, 10, 0, 0, 2, -1, 0};
    tbl[4] = '{1, 3, 12, 4, 2, 0, 0, 1, 0, 3, -1, 1};
    tbl[5] = '{2, 3, 0, 0, 2, 0, 0, 0, 0, 0, -1, 1};
    tbl[6] = '{0, 1, 7, 2, 1, 0, 0, 0, 1, 3, 6, 1};
    tbl[7] = '{15, 1, 3, 0, 2, 0, 0, 0, 0, 3, -1, 1};
    tbl[8] = '{1, 20, 5, 1, 2, 0, 5, 0, 0, 0, -1, 0};

    s_reset = 1'b1;
    signal_load = 1'b0;
    s_acq_en = 1'b0;
    acqnum = '0;
    stripnum = '0;
    s_periodnum = '0;
    s_addchoice = '0;
    s_ADC = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("rst_clk", int'(Signal_acq_clk), 0);
      chk("rst_valid", int'(signal_valid), 0);
      chk("rst_done", int'(acq_done), 0);
      chk("rst_data", int'(signal_data), 0);
    end
    s_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("idle_clk", int'(Signal_acq_clk), 0);
    end

    foreach (tbl[t]) begin
      run_vec(tbl[t], nv, fd, nd);
      chk("run_nvalid", nv, tbl[t].exp_nvalid);
      if (tbl[t].exp_first >= 0) chk("run_first", fd, tbl[t].exp_first);
      chk("run_ndone", nd, tbl[t].exp_ndone);
    end

    // Reset asserted in the middle of a run.
    @(negedge clk_sys);
    acqnum = 16'd20;
    stripnum = 12'd1;
    s_periodnum = 4'd0;
    s_addchoice = 5'd1;
    signal_load = 1'b1;
    @(negedge clk_sys);
    signal_load = 1'b0;
    s_acq_en = 1'b1;
    repeat (8) @(negedge clk_sys);
    s_reset = 1'b1;
    s_acq_en = 1'b0;
    @(negedge clk_sys);
    chk("mrst_clk", int'(Signal_acq_clk), 0);
    chk("mrst_valid", int'(signal_valid), 0);
    chk("mrst_done", int'(acq_done), 0);
    chk("mrst_data", int'(signal_data), 0);
    exp_data = 0;
    s_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("mrst_idle_clk", int'(Signal_acq_clk), 0);
      chk("mrst_idle_valid", int'(signal_valid), 0);
    end

    for (int r = 0; r < 6; r++) begin
      rv.per      = int'($urandom_range(0, 7));
      rv.strip    = int'($urandom_range(0, 6));
      rv.acq      = int'($urandom_range(0, 40));
      rv.add      = int'($urandom_range(0, 31));
      rv.pat      = 2;
      rv.cval     = 0;
      rv.abort_n  = 0;
      rv.mid_load = int'($urandom_range(0, 1));
      rv.same_cyc = int'($urandom_range(0, 1));
      rv.exp_nvalid = (rv.acq + rv.add) / (rv.add + 1);
      rv.exp_first  = -1;
      rv.exp_ndone  = 1;
      run_vec(rv, nv, fd, nd);
      chk("rand_nvalid", nv, rv.exp_nvalid);
      chk("rand_ndone", nd, rv.exp_ndone);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
